acc_drain: RTL and testbench
============================

# acc_drain

Result drain for the processing array. Captures the final accumulator values of `NUM_CH` adder channels in one cycle, issues a clear pulse back to those adders, and streams the captured values out one per beat over a valid/ready interface. On the way out it converts each value from the internal 18-bit FloPoCo format (2 exception bits plus a 16-bit float) to IEEE-754 binary16. It sits between the array's accumulator outputs and the result write-back path.

## Interface
- `BITWIDTH`, 16: float width without exception bits. Element width `EW = BITWIDTH+2`.
- `EXP_W`, 5: exponent width. Fraction width `FRAC_W = BITWIDTH-1-EXP_W`, 10 at defaults.
- `NUM_CH`, 4: number of accumulator channels drained per load. Must be ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  capture strobe; sampled only in IDLE.
- `acc_in`  in  NUM_CH*EW  packed accumulator values; channel k is at `[k*EW +: EW]`.
- `clear_out`  out  1  one-cycle clear pulse to the adders' `clear` input.
- `busy`  out  1  high while in STREAM.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  BITWIDTH  converted binary16 value.
- `m_ch`  out  $clog2(NUM_CH) (min 1)  channel index of the current beat.
- `m_last`  out  1  high on the beat for channel NUM_CH-1.

## Operation
- State machine with two states: IDLE and STREAM. `busy` = (state == STREAM).
- IDLE:
  - When `load` = 1, latch all channels of `acc_in` into the buffer, set `idx` = 0 and go to STREAM.
  - Assert `clear_out` on the next cycle, for exactly one cycle.
- STREAM:
  - `m_valid` = 1; `m_data` = conv(buf[idx]); `m_ch` = idx; `m_last` = (idx == NUM_CH-1).
  - On `m_valid && m_ready`: if `m_last`, go to IDLE; otherwise increment `idx`.
- `load` is ignored while in STREAM, including on the final-handshake cycle. No capture happens and no `clear_out` is issued.
- Outputs are stable while `m_valid && !m_ready`.
- When `m_valid` = 0: `m_data`, `m_ch` and `m_last` read 0.
- conv(x): exc = x[EW-1:EW-2], s = sign bit, e = exponent, f = fraction.
  - exc 00 (zero): {s, 0...0}, so signed zero is preserved.
  - exc 01 (normal):
    - e == 0: flush to {s, 0...0}.
    - e == all-ones: saturate to {s, all-ones exponent, 0 fraction}.
    - otherwise: {s, e, f} unchanged (same bias).
  - exc 10 (infinity): {s, all-ones exponent, 0 fraction}.
  - exc 11 (NaN): {0, all-ones exponent, 1 followed by zeros} = 16'h7E00 at defaults.
- The buffer holds the captured values until the next accepted `load`. `acc_in` changing after capture has no effect on the stream.
- The same-cycle `clear_out` is the only feedback to the adders. The adders resume accumulating from 0 while the drain streams.

## Timing
- Reset values:
  - state IDLE, `idx` 0, buffer all 0.
  - `clear_out` 0, `busy` 0, `m_valid` 0, `m_data` 0, `m_ch` 0, `m_last` 0.
- `load` accepted at cycle t. At t+1: `busy` = 1, `m_valid` = 1 with channel 0, and `clear_out` = 1. At t+2: `clear_out` = 0.
- With `m_ready` held at 1, beats occur at t+1 … t+NUM_CH, `m_last` is high at t+NUM_CH, and the block is back in IDLE at t+NUM_CH+1.
- The earliest next accepted `load` is at t+NUM_CH+1.
- Conversion is combinational from the registered buffer, so there is no added latency.
- `rst` mid-stream: the next cycle shows reset values. The remaining beats are dropped and no `clear_out` is issued.
- `rst` together with `load`: reset wins.
- NUM_CH = 1: a single beat with `m_last` = 1.

## Test plan
- Full stream with no backpressure: channels loaded with 1.0, 2.0, -0.5, 0.0 (all exc 01, 01, 01, 00) and `m_ready` = 1 → `m_data` 3C00, 4000, B800, 0000 on consecutive cycles; `m_last` only on the 4th beat; `clear_out` pulses once, in the cycle after `load`.
- Backpressure: `m_ready` toggles 0,0,1,0,1,1,0,1 → each beat is held stable while not accepted; exactly 4 handshakes occur; `m_ch` goes 0..3 with no skips or repeats.
- Exception coverage:
  - exc 10 with sign 1 → FC00.
  - exc 11 → 7E00.
  - exc 00 with sign 1 → 8000.
  - exc 01 with e = 0 → signed zero.
  - exc 01 with e = 31 → 7C00 or FC00 depending on sign.
- `load` pulsed in STREAM on beat 2 and again on the final-handshake cycle → no recapture, no extra `clear_out`; the next `load` in IDLE captures the new `acc_in`.
- `rst` asserted after beat 1 with `load` also high → all outputs return to reset values the next cycle, and no stream starts until a fresh `load` arrives.
- Input change after capture: `acc_in` changes every cycle during STREAM → the streamed values match the values sampled at the `load` cycle.

Source files
------------

// File: rtl/acc_drain_if.sv
// Output beat channel of the accumulator drain: valid/ready with data, channel index and last flag.
interface acc_drain_if #(
  parameter int BITWIDTH = 16,
  parameter int NUM_CH   = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                m_valid;
  logic                m_ready;
  logic [BITWIDTH-1:0] m_data;
  logic [CH_W-1:0]     m_ch;
  logic                m_last;

  modport master (output m_valid, m_data, m_ch, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_ch, m_last, output m_ready);
endinterface

// File: rtl/acc_drain.sv
// Captures NUM_CH accumulator values in one cycle, pulses clear back to the adders, and streams
// the values out one per beat converted from FloPoCo (exception + float) to IEEE binary16.
module acc_drain #(
  parameter int BITWIDTH = 16,
  parameter int EXP_W    = 5,
  parameter int NUM_CH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NUM_CH*(BITWIDTH+2)-1:0] acc_in,
  output logic                          clear_out,
  output logic                          busy,
  acc_drain_if.master                   m
);
  localparam int EW     = BITWIDTH + 2;
  localparam int FRAC_W = BITWIDTH - 1 - EXP_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic [EW-1:0]   buf_q [NUM_CH];
  logic            clear_q;
  logic            capture;
  logic            last;

  function automatic logic [BITWIDTH-1:0] conv(input logic [EW-1:0] x);
    logic [1:0]       exc;
    logic             s;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    logic [BITWIDTH-1:0] r;
    exc = x[EW-1:EW-2];
    s   = x[BITWIDTH-1];
    e   = x[BITWIDTH-2 -: EXP_W];
    f   = x[FRAC_W-1:0];
    r   = '0;
    case (exc)
      2'b00: r = {s, {(BITWIDTH-1){1'b0}}};
      2'b01: begin
        if (e == '0)
          r = {s, {(BITWIDTH-1){1'b0}}};
        else if (e == '1)
          r = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else
          r = {s, e, f};
      end
      2'b10: r = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      default: r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      clear_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clear_q <= capture;
      if (capture) begin
        for (int k = 0; k < NUM_CH; k++) buf_q[k] <= acc_in[k*EW +: EW];
      end
    end
  end

  assign last = (idx_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture   = 1'b0;
    m.m_valid = 1'b0;
    m.m_data  = '0;
    m.m_ch    = '0;
    m.m_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      default: begin
        m.m_valid = 1'b1;
        m.m_data  = conv(buf_q[idx_q]);
        m.m_ch    = idx_q;
        m.m_last  = last;
        // load is deliberately not looked at here, even on the final handshake
        if (m.m_ready) begin
          if (last) state_d = IDLE;
          else      idx_d   = idx_q + CH_W'(1);
        end
      end
    endcase
  end

  assign clear_out = clear_q;
  assign busy      = (state_q == STREAM);
endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: streaming, backpressure, conversion exceptions, load/rst corner cases.
module tb_acc_drain;
  localparam int EW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*EW-1:0] acc_in;
  logic          clear_out;
  logic          busy;
  int            n_checks = 0;
  int            n_errors = 0;

  acc_drain_if #(.BITWIDTH(16), .NUM_CH(4)) dif ();

  acc_drain #(.BITWIDTH(16), .EXP_W(5), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .acc_in    (acc_in),
    .clear_out (clear_out),
    .busy      (busy),
    .m         (dif.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] fp(input logic [1:0] exc, input logic [15:0] v);
    return {exc, v};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_valid"}, 32'(dif.m_valid), 32'd0);
    check({tag, "_data"},  32'(dif.m_data),  32'd0);
    check({tag, "_ch"},    32'(dif.m_ch),    32'd0);
    check({tag, "_last"},  32'(dif.m_last),  32'd0);
    check({tag, "_clr"},   32'(clear_out),   32'd0);
  endtask

  // Loads acc, streams with m_ready=1, checks every beat; scramble drives junk on acc_in after capture.
  task automatic run_stream(input string tag, input logic [4*EW-1:0] acc,
                            input logic [63:0] exp, input bit scramble);
    logic [95:0] junk;
    acc_in     = acc;
    load       = 1'b1;
    dif.m_ready = 1'b1;
    check({tag, "_clr_pre"}, 32'(clear_out), 32'd0);
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (scramble) begin
        junk   = {$urandom(), $urandom(), $urandom()};
        acc_in = junk[4*EW-1:0];
      end
      check($sformatf("%s_valid%0d", tag, i), 32'(dif.m_valid), 32'd1);
      check($sformatf("%s_busy%0d", tag, i),  32'(busy),        32'd1);
      check($sformatf("%s_ch%0d", tag, i),    32'(dif.m_ch),    32'(i));
      check($sformatf("%s_data%0d", tag, i),  32'(dif.m_data),  32'(exp[i*16 +: 16]));
      check($sformatf("%s_last%0d", tag, i),  32'(dif.m_last),  32'(i == 3));
      check($sformatf("%s_clr%0d", tag, i),   32'(clear_out),   32'(i == 0));
      step();
    end
    check_idle({tag, "_end"});
  endtask

  logic [4*EW-1:0] acc_a, acc_b, acc_e1, acc_e2;
  logic [63:0]     exp_a, exp_b, exp_e1, exp_e2;
  logic [7:0]      rdy_pat;
  int              exp_ch, hs;

  initial begin
    acc_a  = {fp(2'b00, 16'h0000), fp(2'b01, 16'hB800), fp(2'b01, 16'h4000), fp(2'b01, 16'h3C00)};
    exp_a  = {16'h0000, 16'hB800, 16'h4000, 16'h3C00};
    acc_b  = {fp(2'b01, 16'h4444), fp(2'b01, 16'h3333), fp(2'b01, 16'h2222), fp(2'b01, 16'h1111)};
    exp_b  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    acc_e1 = {fp(2'b01, 16'h83FF), fp(2'b00, 16'h8ABC), fp(2'b11, 16'h1234), fp(2'b10, 16'h8123)};
    exp_e1 = {16'h8000, 16'h8000, 16'h7E00, 16'hFC00};
    acc_e2 = {fp(2'b01, 16'h5555), fp(2'b01, 16'h03FF), fp(2'b01, 16'hFFFF), fp(2'b01, 16'h7C03)};
    exp_e2 = {16'h5555, 16'h0000, 16'hFC00, 16'h7C00};

    rst = 1'b1; load = 1'b0; acc_in = '0; dif.m_ready = 1'b0;
    step(); step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("idle_noload");

    run_stream("basic", acc_a, exp_a, 1'b0);
    run_stream("exc1", acc_e1, exp_e1, 1'b0);
    run_stream("exc2", acc_e2, exp_e2, 1'b0);

    // backpressure
    rdy_pat = 8'b1011_0100;  // bit i = m_ready in cycle i: 0,0,1,0,1,1,0,1
    acc_in = acc_b; load = 1'b1;
    step();
    load = 1'b0;
    exp_ch = 0; hs = 0;
    for (int i = 0; i < 8; i++) begin
      dif.m_ready = rdy_pat[i];
      check($sformatf("bp_valid%0d", i), 32'(dif.m_valid), 32'd1);
      check($sformatf("bp_ch%0d", i),    32'(dif.m_ch),    32'(exp_ch));
      check($sformatf("bp_data%0d", i),  32'(dif.m_data),  32'(exp_b[exp_ch*16 +: 16]));
      check($sformatf("bp_last%0d", i),  32'(dif.m_last),  32'(exp_ch == 3));
      if (dif.m_valid && dif.m_ready) begin
        hs++;
        exp_ch++;
      end
      step();
    end
    check("bp_handshakes", 32'(hs), 32'd4);
    check_idle("bp_end");

    // load pulsed inside STREAM is ignored
    dif.m_ready = 1'b1;
    acc_in = acc_a; load = 1'b1;
    step();
    load = 1'b0; acc_in = acc_b;
    check("ign_ch0", 32'(dif.m_data), 32'(exp_a[15:0]));
    step();
    load = 1'b1;
    check("ign_ch1", 32'(dif.m_data), 32'(exp_a[31:16]));
    step();
    load = 1'b0;
    check("ign_ch2", 32'(dif.m_data), 32'(exp_a[47:32]));
    check("ign_clr2", 32'(clear_out), 32'd0);
    step();
    load = 1'b1;
    check("ign_ch3", 32'(dif.m_data), 32'(exp_a[63:48]));
    check("ign_last", 32'(dif.m_last), 32'd1);
    step();
    load = 1'b0;
    check_idle("ign_after");
    step();
    check_idle("ign_after2");
    run_stream("ign_reload", acc_b, exp_b, 1'b0);

    // rst mid-stream with load high
    acc_in = acc_e1; load = 1'b1; dif.m_ready = 1'b1;
    step();
    load = 1'b0;
    step();
    check("rst_pre_ch", 32'(dif.m_ch), 32'd1);
    rst = 1'b1; load = 1'b1;
    step();
    check_idle("rst_hit");
    rst = 1'b0; load = 1'b0;
    step(); step();
    check_idle("rst_quiet");
    run_stream("rst_fresh", acc_a, exp_a, 1'b0);

    run_stream("scramble", acc_e2, exp_e2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
